// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: sample width, saturation limits and
// the accumulator state encoding.
package dsp_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Combinational adder built from 4-bit carry-lookahead groups, with the
// group carries chained. WIDTH must be a multiple of 4.
module carry_lookahead_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NGRP = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;

    always_comb begin
        logic carry;
        logic grp_g;
        logic grp_p;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        carry = cin;
        grp_g = 1'b0;
        grp_p = 1'b0;
        for (int k = 0; k < int'(NGRP); k++) begin
            c[4*k]   = carry;
            c[4*k+1] = g[4*k] | (p[4*k] & carry);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            grp_g    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p    = &p[4*k +: 4];
            carry    = grp_g | (grp_p & carry);
        end
        sum  = p ^ c;
        cout = carry;
    end

endmodule

// File: rtl/frame_accumulator.sv
// Signed frame accumulator: sums FRAME_LEN samples through one adder,
// optionally saturating, and hands each frame sum out over valid/ready.
module frame_accumulator
    import dsp_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_overflow
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    acc_state_t        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout_unused;
    logic              ovf;
    logic [DATA_W-1:0] next_val;

    carry_lookahead_adder #(
        .WIDTH(DATA_W)
    ) u_adder (
        .a   (acc_q),
        .b   (in_data),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout_unused)
    );

    // Signed overflow: equal operand signs but the result sign differs.
    always_comb begin
        ovf      = (acc_q[DATA_W-1] == in_data[DATA_W-1]) &&
                   (add_sum[DATA_W-1] != acc_q[DATA_W-1]);
        next_val = add_sum;
        if (SATURATE && ovf) begin
            next_val = acc_q[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            state_d     = ACC;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            out_data_d  = '0;
            out_ovf_d   = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (in_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            out_data_d  = next_val;
                            out_ovf_d   = sticky_q | ovf;
                            out_valid_d = 1'b1;
                            state_d     = HOLD;
                            acc_d       = '0;
                            cnt_d       = '0;
                            sticky_d    = 1'b0;
                        end else begin
                            acc_d    = next_val;
                            cnt_d    = cnt_q + CNT_W'(1);
                            sticky_d = sticky_q | ovf;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ACC;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = (state_q == ACC);
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_frame_accumulator.sv
// Bench for frame_accumulator: a saturating and a wrapping instance share
// stimulus and are checked against an integer-arithmetic frame model.
module tb_frame_accumulator;

    localparam int unsigned FL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [15:0] out_data_s;
    logic        in_ready_w, out_valid_w, out_ovf_w;
    logic [15:0] out_data_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_q[$];
    bit          m_pend;
    logic [15:0] m_ds, m_dw;
    bit          m_os, m_ow;

    always #5 clk = ~clk;

    frame_accumulator #(.FRAME_LEN(FL), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_overflow(out_ovf_s)
    );

    frame_accumulator #(.FRAME_LEN(FL), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .out_overflow(out_ovf_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame sum as true integer arithmetic, clamped or wrapped afterwards.
    task automatic ref_frame(output logic [15:0] ds, output logic [15:0] dw,
                             output bit os, output bit ow);
        int acc_s, acc_w, t;
        logic signed [15:0] xs, tw;
        acc_s = 0; acc_w = 0; os = 0; ow = 0;
        foreach (m_q[i]) begin
            xs = m_q[i];
            t  = acc_s + int'(xs);
            if (t > 32767)       begin os = 1; acc_s = 32767;  end
            else if (t < -32768) begin os = 1; acc_s = -32768; end
            else                 acc_s = t;
            t  = acc_w + int'(xs);
            if (t > 32767 || t < -32768) ow = 1;
            tw    = 16'(t);
            acc_w = int'(tw);
        end
        ds = 16'(acc_s);
        dw = 16'(acc_w);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 0;
        m_ds = '0; m_dw = '0; m_os = 0; m_ow = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":in_ready_s"},  32'(in_ready_s),  32'(!m_pend));
        chk({tag, ":in_ready_w"},  32'(in_ready_w),  32'(!m_pend));
        chk({tag, ":out_valid_s"}, 32'(out_valid_s), 32'(m_pend));
        chk({tag, ":out_valid_w"}, 32'(out_valid_w), 32'(m_pend));
        chk({tag, ":out_data_s"},  32'(out_data_s),  32'(m_ds));
        chk({tag, ":out_data_w"},  32'(out_data_w),  32'(m_dw));
        chk({tag, ":out_ovf_s"},   32'(out_ovf_s),   32'(m_os));
        chk({tag, ":out_ovf_w"},   32'(out_ovf_w),   32'(m_ow));
    endtask

    // One clock: drive at posedge+1, check in_ready mid-cycle, update model
    // at the edge, check registered outputs at posedge+1.
    task automatic step(input bit v, input logic [15:0] d, input bit rdy, input bit clr,
                        input string tag);
        in_valid = v; in_data = d; out_ready = rdy; clear = clr;
        #3;
        chk({tag, ":pre_in_ready_s"}, 32'(in_ready_s), 32'(!m_pend));
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (!m_pend) begin
            if (v) begin
                m_q.push_back(d);
                if (m_q.size() == FL) begin
                    ref_frame(m_ds, m_dw, m_os, m_ow);
                    m_q.delete();
                    m_pend = 1;
                end
            end
        end else if (rdy) begin
            m_pend = 0;
        end
        #1;
        check_outs(tag);
    endtask

    task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d, input string tag);
        step(1, a, 1, 0, tag);
        step(1, b, 1, 0, tag);
        step(1, c, 1, 0, tag);
        step(1, d, 1, 0, tag);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #12;
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1+2+3+4, out_valid high for one cycle
        frame4(16'd1, 16'd2, 16'd3, 16'd4, "seq");
        chk("seq_sum_s", 32'(out_data_s), 32'h000A);
        chk("seq_sum_w", 32'(out_data_w), 32'h000A);
        chk("seq_vld",   32'(out_valid_s), 32'd1);
        step(0, '0, 1, 0, "seq_drain");
        chk("seq_vld_drop", 32'(out_valid_s), 32'd0);

        // positive overflow: clamp vs wrap
        frame4(16'h7000, 16'h7000, 16'h0001, 16'hFFFF, "pos_ovf");
        chk("pos_sat_data", 32'(out_data_s), 32'h7FFE);
        chk("pos_sat_ovf",  32'(out_ovf_s),  32'd1);
        chk("pos_wrap_data", 32'(out_data_w), 32'hE000);
        chk("pos_wrap_ovf",  32'(out_ovf_w),  32'd1);
        step(0, '0, 1, 0, "pos_drain");

        // negative overflow
        frame4(16'h8000, 16'hFFFF, 16'h0000, 16'h0000, "neg_ovf");
        chk("neg_sat_data", 32'(out_data_s), 32'h8000);
        chk("neg_sat_ovf",  32'(out_ovf_s),  32'd1);

        // backpressure with in_valid held high
        for (int i = 0; i < 5; i++) step(1, 16'h1234, 0, 0, "bp_hold");
        chk("bp_hold_data", 32'(out_data_s), 32'h8000);
        step(0, '0, 1, 0, "bp_release");
        frame4(16'd2, 16'd2, 16'd2, 16'd2, "bp_next");
        chk("bp_next_sum", 32'(out_data_s), 32'h0008);
        chk("bp_next_ovf", 32'(out_ovf_s),  32'd0);
        step(0, '0, 1, 0, "bp_drain");

        // clear mid-frame drops partial sum and the concurrent sample
        step(1, 16'd100, 1, 0, "clr_pre");
        step(1, 16'd100, 1, 0, "clr_pre");
        step(1, 16'd7, 1, 1, "clr");
        frame4(16'd5, 16'd5, 16'd5, 16'd5, "clr_next");
        chk("clr_next_sum", 32'(out_data_s), 32'h0014);
        step(0, '0, 1, 0, "clr_drain");

        // async reset mid-frame, asserted between edges
        step(1, 16'd100, 1, 0, "rst_pre");
        step(1, 16'd100, 1, 0, "rst_pre");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("rst_async");
        chk("rst_async_data", 32'(out_data_s), 32'h0000);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        frame4(16'd5, 16'd5, 16'd5, 16'd5, "rst_next");
        chk("rst_next_sum", 32'(out_data_s), 32'h0014);
        step(0, '0, 1, 0, "rst_drain");

        // randomized traffic with extremes mixed in
        for (int i = 0; i < 600; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 4))
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                2:       d = 16'($urandom_range(0, 15)) - 16'd8;
                default: d = 16'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
